// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, polarity normalization,
// counter-based debounce filter and registered press/release pulses per channel.
// Optional sticky press latch with per-channel clear, enabled by defining
// BUTTON_DEBOUNCE_STICKY_EN (adds press_clear input and press_sticky output).

module button_debounce #(
    parameter int unsigned WIDTH           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_raw,
`ifdef BUTTON_DEBOUNCE_STICKY_EN
    input  logic [WIDTH-1:0] press_clear,
    output logic [WIDTH-1:0] press_sticky,
`endif
    output logic [WIDTH-1:0] btn_stable,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
);

    localparam int unsigned      CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0]  CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] RawIdle = {WIDTH{ACTIVE_LOW}};

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];

    // Synchronizer next state and polarity normalization (1 = pressed).
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level   = ACTIVE_LOW ? ~sync2_q : sync2_q;
    end

    // Debounce counters: accept a new level only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (level[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                accept[i] = 1'b1;
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
        stable_d  = stable_q ^ accept;
        press_d   = accept & level;
        release_d = accept & ~level;
    end

    // State registers; sync flops reset to the raw idle level so reset never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= RawIdle;
            sync2_q   <= RawIdle;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_stable  = stable_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef BUTTON_DEBOUNCE_STICKY_EN
    logic [WIDTH-1:0] sticky_q, sticky_d;

    // Sticky latch: a press pulse sets the bit and wins over a simultaneous clear.
    always_comb begin
        sticky_d = (sticky_q & ~press_clear) | press_q;
    end

    // Sticky register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign press_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a sliding-window model.

module tb_button_debounce;

    localparam int W  = 3;
    localparam int D  = 4;
    localparam bit AL = 1'b1;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] btn_raw;
    logic [W-1:0] btn_stable;
    logic [W-1:0] btn_press;
    logic [W-1:0] btn_release;
`ifdef BUTTON_DEBOUNCE_STICKY_EN
    logic [W-1:0] press_clear;
    logic [W-1:0] press_sticky;
`endif

    button_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (AL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
`ifdef BUTTON_DEBOUNCE_STICKY_EN
        .press_clear (press_clear),
        .press_sticky(press_sticky),
`endif
        .btn_stable (btn_stable),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: raw samples pass a two-deep delay; a channel takes the new level
    // once the last D normalized samples all disagree with the accepted level.
    logic [W-1:0] m_s1, m_s2, m_stable, m_press, m_rel, m_sticky;
    logic [W-1:0] win[$];

    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] stable;
        logic [W-1:0] press;
        logic [W-1:0] rel;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1     = {W{AL}};
        m_s2     = {W{AL}};
        m_stable = '0;
        m_press  = '0;
        m_rel    = '0;
        m_sticky = '0;
        win.delete();
    endtask

    task automatic model_edge();
        logic [W-1:0] n;
        logic [W-1:0] acc;
        bit           all_diff;
        n = AL ? ~m_s2 : m_s2;
        win.push_back(n);
        if (win.size() > D) void'(win.pop_front());
        acc = '0;
        if (win.size() == D) begin
            for (int ch = 0; ch < W; ch++) begin
                all_diff = 1'b1;
                foreach (win[j]) if (win[j][ch] == m_stable[ch]) all_diff = 1'b0;
                acc[ch] = all_diff;
            end
        end
`ifdef BUTTON_DEBOUNCE_STICKY_EN
        m_sticky = (m_sticky & ~press_clear) | m_press;
`endif
        m_press  = acc & n;
        m_rel    = acc & ~n;
        m_stable = m_stable ^ acc;
        m_s2     = m_s1;
        m_s1     = btn_raw;
    endtask

    // One clock edge: advance model, then compare every output against it.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        check("model_stable", {29'd0, btn_stable}, {29'd0, m_stable});
        check("model_press", {29'd0, btn_press}, {29'd0, m_press});
        check("model_release", {29'd0, btn_release}, {29'd0, m_rel});
`ifdef BUTTON_DEBOUNCE_STICKY_EN
        check("model_sticky", {29'd0, press_sticky}, {29'd0, m_sticky});
`endif
    endtask

    task automatic add_rows(input int n, input logic [W-1:0] raw, input logic [W-1:0] st,
                            input logic [W-1:0] pr, input logic [W-1:0] rl);
        vec_t v;
        v.raw = raw; v.stable = st; v.press = pr; v.rel = rl;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int npress;
        int press_at;
        bit seen;

        // Reset with all buttons idle (raw high).
        btn_raw = '1;
`ifdef BUTTON_DEBOUNCE_STICKY_EN
        press_clear = '0;
`endif
        reset = 1'b1;
        model_reset();
        repeat (3) tick();
        check("rst_stable", {29'd0, btn_stable}, 32'd0);
        check("rst_press", {29'd0, btn_press}, 32'd0);
        check("rst_release", {29'd0, btn_release}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_no_press", {29'd0, btn_press}, 32'd0);
        end

        // Clean press/release on ch0, then simultaneous press/release on ch0 and ch2.
        add_rows(5, 3'b110, 3'b000, 3'b000, 3'b000);
        add_rows(1, 3'b110, 3'b001, 3'b001, 3'b000);
        add_rows(2, 3'b110, 3'b001, 3'b000, 3'b000);
        add_rows(5, 3'b111, 3'b001, 3'b000, 3'b000);
        add_rows(1, 3'b111, 3'b000, 3'b000, 3'b001);
        add_rows(1, 3'b111, 3'b000, 3'b000, 3'b000);
        add_rows(5, 3'b010, 3'b000, 3'b000, 3'b000);
        add_rows(1, 3'b010, 3'b101, 3'b101, 3'b000);
        add_rows(1, 3'b010, 3'b101, 3'b000, 3'b000);
        add_rows(5, 3'b111, 3'b101, 3'b000, 3'b000);
        add_rows(1, 3'b111, 3'b000, 3'b000, 3'b101);
        add_rows(1, 3'b111, 3'b000, 3'b000, 3'b000);
        foreach (vecs[i]) begin
            btn_raw = vecs[i].raw;
            tick();
            check("tbl_stable", {29'd0, btn_stable}, {29'd0, vecs[i].stable});
            check("tbl_press", {29'd0, btn_press}, {29'd0, vecs[i].press});
            check("tbl_release", {29'd0, btn_release}, {29'd0, vecs[i].rel});
        end

        // Bounce on ch1: 3 low / 1 high, five times, then held low.
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                btn_raw[1] = (k == 3);
                tick();
                check("bounce_hold", {31'd0, btn_stable[1]}, 32'd0);
                check("bounce_no_press", {31'd0, btn_press[1]}, 32'd0);
            end
        end
        btn_raw[1] = 1'b0;
        npress   = 0;
        press_at = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (btn_press[1]) begin
                npress++;
                press_at = k;
            end
        end
        check("bounce_press_count", npress, 32'd1);
        check("bounce_press_time", press_at, 32'd5);
        btn_raw = '1;
        repeat (8) tick();

        // Reset after two counted cycles with ch0 held.
        btn_raw = 3'b110;
        repeat (4) tick();
        reset = 1'b1;
        model_reset();
        #1;
        check("midrst_stable", {29'd0, btn_stable}, 32'd0);
        repeat (2) tick();
        check("midrst_stable_held", {29'd0, btn_stable}, 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) check("midrst_not_yet", {31'd0, btn_stable[0]}, 32'd0);
            if (k == 6) begin
                check("midrst_stable_after", {29'd0, btn_stable}, 32'd1);
                check("midrst_press_after", {29'd0, btn_press}, 32'd1);
            end
        end
        btn_raw = '1;
        repeat (8) tick();

`ifdef BUTTON_DEBOUNCE_STICKY_EN
        // Sticky set, hold, clear, then set-wins-over-clear.
        btn_raw = 3'b110;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            seen = btn_press[0];
        end
        check("sticky_press_seen", {31'd0, seen}, 32'd1);
        tick();
        check("sticky_set", {29'd0, press_sticky}, 32'd1);
        repeat (2) tick();
        check("sticky_hold", {29'd0, press_sticky}, 32'd1);
        press_clear = 3'b001;
        tick();
        press_clear = '0;
        check("sticky_clear", {29'd0, press_sticky}, 32'd0);
        btn_raw = '1;
        repeat (8) tick();
        btn_raw = 3'b110;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            seen = btn_press[0];
        end
        check("sticky_press_seen2", {31'd0, seen}, 32'd1);
        press_clear = 3'b001;
        tick();
        press_clear = '0;
        check("sticky_set_wins", {29'd0, press_sticky}, 32'd1);
        btn_raw = '1;
        repeat (8) tick();
`else
        seen = 1'b0;
`endif

        // Randomized run: sparse toggles so some levels survive the filter, rare resets.
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < W; ch++) begin
                if ($urandom_range(7) == 0) btn_raw[ch] = ~btn_raw[ch];
            end
`ifdef BUTTON_DEBOUNCE_STICKY_EN
            for (int ch = 0; ch < W; ch++) press_clear[ch] = ($urandom_range(3) == 0);
`endif
            if ($urandom_range(499) == 0) begin
                reset = 1'b1;
                model_reset();
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
